// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 timing constants and frame-buffer address helper
package vga_timing_pkg;
  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE     = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int IMG_W        = 160;
  localparam int IMG_H        = 120;
  localparam int MAX_ADDR     = IMG_W * IMG_H - 1;
  localparam int PIPE_DEPTH   = 2;

  // row*160 + col without a multiplier
  function automatic logic [14:0] pix_addr(input logic [7:0] row, input logic [7:0] col);
    return ({7'd0, row} << 7) + ({7'd0, row} << 5) + {7'd0, col};
  endfunction
endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - hcnt/vcnt raster counters with raw active, sync and origin flags
module vga_sync_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] src_col,
  output logic [7:0] src_row,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       origin
);
  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcnt;
  logic [9:0] vcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // 4x replication: each source pixel/row spans four clocks/lines
  assign src_col = hcnt[9:2];
  assign src_row = vcnt[9:2];
  assign active  = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hsync   = !((hcnt >= HS_START) && (hcnt < HS_END));
  assign vsync   = !((vcnt >= VS_START) && (vcnt < VS_END));
  assign origin  = (hcnt == 10'd0) && (vcnt == 10'd0);
endmodule

// File: rtl/vga_fb_reader.sv
// rtl/vga_fb_reader.sv - frame-buffer read controller: address generation, 2-stage alignment, colour gating
module vga_fb_reader #(
  parameter int AW       = 15,
  parameter int DW       = 12,
  parameter int IMG_W    = vga_timing_pkg::IMG_W,
  parameter int IMG_H    = vga_timing_pkg::IMG_H,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] addr_out,
  input  logic [DW-1:0] data_in,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_start
);
  import vga_timing_pkg::*;

  localparam logic [7:0] COL_LIM = 8'(IMG_W);
  localparam logic [7:0] ROW_LIM = 8'(IMG_H);

  logic [7:0] src_col;
  logic [7:0] src_row;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic       origin;
  logic       in_image;
  logic       show;

  logic [PIPE_DEPTH-1:0] act_pipe;
  logic [PIPE_DEPTH-1:0] hs_pipe;
  logic [PIPE_DEPTH-1:0] vs_pipe;
  logic [PIPE_DEPTH-1:0] org_pipe;

  vga_sync_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .src_col (src_col),
    .src_row (src_row),
    .active  (active),
    .hsync   (hs_raw),
    .vsync   (vs_raw),
    .origin  (origin)
  );

  // Address is parked at 0 outside the image so blanking never reads past MAX_ADDR
  assign in_image = active && (src_col < COL_LIM) && (src_row < ROW_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_out <= '0;
      act_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      org_pipe <= '0;
    end else begin
      addr_out <= in_image ? AW'(pix_addr(src_row, src_col)) : '0;
      act_pipe <= {act_pipe[PIPE_DEPTH-2:0], active};
      hs_pipe  <= {hs_pipe[PIPE_DEPTH-2:0], hs_raw};
      vs_pipe  <= {vs_pipe[PIPE_DEPTH-2:0], vs_raw};
      org_pipe <= {org_pipe[PIPE_DEPTH-2:0], origin};
    end
  end

  // Colour is unregistered: data_in already sits at stage 2
  assign show        = act_pipe[PIPE_DEPTH-1];
  assign vga_hsync   = hs_pipe[PIPE_DEPTH-1];
  assign vga_vsync   = vs_pipe[PIPE_DEPTH-1];
  assign frame_start = org_pipe[PIPE_DEPTH-1];
  assign vga_r       = show ? data_in[11:8] : 4'd0;
  assign vga_g       = show ? data_in[7:4]  : 4'd0;
  assign vga_b       = show ? data_in[3:0]  : 4'd0;
endmodule
